// File: rtl/mr_alu_arb_pkg.sv
// mr_alu_arb_pkg: shared types and constants for the ALU arbiter slice.
//   XLEN              datapath width seen by mr_alu
//   e_aluops          ALU operation encoding (shared with mr_alu)
//   alu_issue_t       one ALU issue slot (op + two operands)
//   MR_ALU_ARB_MAXREQ upper bound on requesters
//   rr_ptr_w()        round-robin pointer width, never below 1 bit
package mr_alu_arb_pkg;

    localparam int XLEN              = 32;
    localparam int MR_ALU_ARB_MAXREQ = 8;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_AND     = 4'd2,
        ALU_OR      = 4'd3,
        ALU_XOR     = 4'd4,
        ALU_SLL     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_CMP_LT  = 4'd8,
        ALU_CMP_LTU = 4'd9
    } e_aluops;

    typedef struct packed {
        e_aluops           op;
        logic [XLEN-1:0]   arg1;
        logic [XLEN-1:0]   arg2;
    } alu_issue_t;

    function automatic int rr_ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mr_alu_arb_rr.sv
// mr_rr_arb: combinational round-robin arbiter.
//   i_elig   eligible vector, one bit per requester
//   i_ptr    highest-priority requester index this cycle
//   o_grant  one-hot grant (zero when nothing is eligible)
//   o_idx    encoded index of the grant (0 when none)
//   o_any    a grant was issued
// Owner of the pointer is the caller, so the same arbiter can serve other
// shared resources with their own pointer-update policy.
module mr_rr_arb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int k;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        k       = 0;
        // Scan starting at the pointer, wrapping; first eligible wins.
        for (int off = 0; off < N; off++) begin
            k = (int'(i_ptr) + off) % N;
            if (!o_any && i_elig[k]) begin
                o_grant[k] = 1'b1;
                o_idx      = PW'(k);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mr_alu_arb.sv
// mr_alu_arb: shares one mr_alu between NREQ requesters.
//   i_clk, i_rst                 clock, async active-low reset
//   i_req_valid/o_req_ready      request handshake (ready is the one-hot grant)
//   i_req_op/arg1/arg2           per-requester operation and operands
//   o_rsp_valid/i_rsp_ready      response handshake per requester
//   o_rsp_data                   per-requester result
//   o_alu_op/arg1/arg2           issue to mr_alu (ADD 0,0 when idle)
//   i_alu_dest                   mr_alu result, one cycle after issue
//   o_busy                       any result in flight or held
// Each requester owns at most one outstanding result: either in flight
// (passed straight through from i_alu_dest) or parked in its hold register.
module mr_alu_arb
    import mr_alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NREQ-1:0]            i_req_valid,
    output logic [NREQ-1:0]            o_req_ready,
    input  e_aluops [NREQ-1:0]         i_req_op,
    input  logic [NREQ-1:0][XLEN-1:0]  i_req_arg1,
    input  logic [NREQ-1:0][XLEN-1:0]  i_req_arg2,
    output logic [NREQ-1:0]            o_rsp_valid,
    input  logic [NREQ-1:0]            i_rsp_ready,
    output logic [NREQ-1:0][XLEN-1:0]  o_rsp_data,
    output logic [XLEN-1:0]            o_alu_arg1,
    output logic [XLEN-1:0]            o_alu_arg2,
    output e_aluops                    o_alu_op,
    input  logic [XLEN-1:0]            i_alu_dest,
    output logic                       o_busy
);

    localparam int PW = rr_ptr_w(NREQ);

    logic [PW-1:0]             r_rr_ptr;
    logic [NREQ-1:0]           r_inflight;
    logic [NREQ-1:0]           r_held;
    logic [NREQ-1:0][XLEN-1:0] r_hold_data;

    logic [NREQ-1:0]           w_pop;
    logic [NREQ-1:0]           w_elig;
    logic [NREQ-1:0]           w_grant;
    logic [PW-1:0]             w_idx;
    logic                      w_any;
    alu_issue_t                w_issue;

    // Response side. A requester whose slot drains this cycle is eligible
    // again immediately, which is what allows back-to-back issue.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        w_pop       = '0;
        w_elig      = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_rsp_valid[i] = r_inflight[i] | r_held[i];
            w_pop[i]       = o_rsp_valid[i] & i_rsp_ready[i];
            w_elig[i]      = i_req_valid[i] & (~o_rsp_valid[i] | w_pop[i]);
            if (r_inflight[i])
                o_rsp_data[i] = i_alu_dest;
            else if (r_held[i])
                o_rsp_data[i] = r_hold_data[i];
        end
    end

    mr_rr_arb #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // One-hot mux onto the ALU; idle slots issue a harmless ADD 0,0.
    always_comb begin
        w_issue.op   = ALU_ADD;
        w_issue.arg1 = '0;
        w_issue.arg2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_issue.op   = i_req_op[i];
                w_issue.arg1 = i_req_arg1[i];
                w_issue.arg2 = i_req_arg2[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr_ptr    <= '0;
            r_inflight  <= '0;
            r_held      <= '0;
            r_hold_data <= '0;
        end else begin
            r_inflight <= w_grant;
            if (w_any)
                r_rr_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                // A pass-through result the consumer refused gets parked.
                if (r_inflight[i] && !i_rsp_ready[i]) begin
                    r_held[i]      <= 1'b1;
                    r_hold_data[i] <= i_alu_dest;
                end else if (w_pop[i]) begin
                    r_held[i] <= 1'b0;
                end
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_alu_op    = w_issue.op;
    assign o_alu_arg1  = w_issue.arg1;
    assign o_alu_arg2  = w_issue.arg2;
    assign o_busy      = |(r_inflight | r_held);

endmodule

// File: tb/tb_mr_alu_arb.sv
// tb_mr_alu_arb: directed + randomized bench for mr_alu_arb (NREQ = 4).
// A stand-in mr_alu computes registered results. The reference model tracks
// one outstanding result per requester as (pending, value) and picks grants
// by scanning from a round-robin pointer.
module tb_mr_alu_arb;
    import mr_alu_arb_pkg::*;

    localparam int NREQ = 4;

    logic                      clk;
    logic                      rst;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    e_aluops [NREQ-1:0]        req_op;
    logic [NREQ-1:0][XLEN-1:0] req_a1;
    logic [NREQ-1:0][XLEN-1:0] req_a2;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready;
    logic [NREQ-1:0][XLEN-1:0] rsp_data;
    logic [XLEN-1:0]           alu_a1;
    logic [XLEN-1:0]           alu_a2;
    e_aluops                   alu_op;
    logic [XLEN-1:0]           alu_dest;
    logic                      busy;

    int tests = 0;
    int fails = 0;

    // reference model state
    int              m_ptr;
    logic [NREQ-1:0] m_pend;
    logic [31:0]     m_val [NREQ];
    int              g_last;

    mr_alu_arb #(.NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_arg1  (req_a1),
        .i_req_arg2  (req_a2),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_alu_arg1  (alu_a1),
        .o_alu_arg2  (alu_a2),
        .o_alu_op    (alu_op),
        .i_alu_dest  (alu_dest),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input e_aluops op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_ADD:     return a + b;
            ALU_SUB:     return a - b;
            ALU_AND:     return a & b;
            ALU_OR:      return a | b;
            ALU_XOR:     return a ^ b;
            ALU_SLL:     return a << b[4:0];
            ALU_SRL:     return a >> b[4:0];
            ALU_SRA:     return 32'($signed(a) >>> b[4:0]);
            ALU_CMP_LT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_CMP_LTU: return {31'b0, a < b};
            default:     return 32'h0;
        endcase
    endfunction

    // stand-in for the shared mr_alu: one registered cycle of latency
    always @(posedge clk) alu_dest <= alu_ref(alu_op, alu_a1, alu_a2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_pend = '0;
        for (int i = 0; i < NREQ; i++) m_val[i] = 32'h0;
    endtask

    task automatic set_req(input int i, input e_aluops op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[i] = op;
        req_a1[i] = a;
        req_a2[i] = b;
    endtask

    // Called just after a falling edge with inputs driven: checks every
    // output against the model, clocks once, advances the model.
    task automatic step(input string tag);
        int g;
        g = -1;
        for (int o = 0; o < NREQ; o++) begin
            int k;
            k = (m_ptr + o) % NREQ;
            if (g < 0 && req_valid[k] && (!m_pend[k] || rsp_ready[k])) g = k;
        end
        #2;
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("%s.ready%0d", tag, i), 32'(req_ready[i]), 32'(g == i));
            chk($sformatf("%s.rvld%0d", tag, i), 32'(rsp_valid[i]), 32'(m_pend[i]));
            chk($sformatf("%s.rdat%0d", tag, i), rsp_data[i], m_pend[i] ? m_val[i] : 32'h0);
        end
        chk({tag, ".aluop"}, 32'(alu_op), (g >= 0) ? 32'(req_op[g]) : 32'(ALU_ADD));
        chk({tag, ".alua1"}, alu_a1, (g >= 0) ? req_a1[g] : 32'h0);
        chk({tag, ".alua2"}, alu_a2, (g >= 0) ? req_a2[g] : 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'(|m_pend));
        @(posedge clk);
        for (int i = 0; i < NREQ; i++)
            if (m_pend[i] && rsp_ready[i]) m_pend[i] = 1'b0;
        if (g >= 0) begin
            m_pend[g] = 1'b1;
            m_val[g]  = alu_ref(req_op[g], req_a1[g], req_a2[g]);
            m_ptr     = (g + 1) % NREQ;
        end
        g_last = g;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g [4];
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'h0, 32'h0);
        model_reset();
        g_last = -1;

        // reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst.ready", 32'(req_ready), 32'h0);
        chk("rst.rvld", 32'(rsp_valid), 32'h0);
        chk("rst.rdat0", rsp_data[0], 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.aluop", 32'(alu_op), 32'(ALU_ADD));
        chk("rst.alua", alu_a1 | alu_a2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // idle
        step("idle0");
        step("idle1");

        // two requesters valid continuously: alternate 0,1,0,1
        set_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        set_req(1, ALU_CMP_LT, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0011;
        exp_g = '{0, 1, 0, 1};
        for (int c = 0; c < 4; c++) begin
            step($sformatf("alt%0d", c));
            chk($sformatf("alt%0d.grant", c), 32'(g_last), 32'(exp_g[c]));
            chk($sformatf("alt%0d.data", c), rsp_data[exp_g[c]],
                (exp_g[c] == 0) ? 32'h0000_00FF : 32'h0000_0001);
        end
        req_valid = '0;
        step("alt.drain");

        // single requester, back-to-back
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 4'b0001;
        step("add");
        chk("add.grant", 32'(g_last), 32'd0);
        chk("add.data", rsp_data[0], 32'd12);
        set_req(0, ALU_SUB, 32'd3, 32'd5);
        step("sub");
        chk("sub.grant", 32'(g_last), 32'd0);
        chk("sub.data", rsp_data[0], 32'hFFFF_FFFE);
        req_valid = '0;
        step("sub.drain");

        // stalled consumer on req0 for three cycles
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        req_valid = 4'b0001;
        step("stall.iss");
        chk("stall.iss.grant", 32'(g_last), 32'd0);
        rsp_ready = 4'b1110;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        set_req(1, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            step($sformatf("stall%0d", c));
            chk($sformatf("stall%0d.grant", c), 32'(g_last), 32'd1);
            chk($sformatf("stall%0d.hold", c), rsp_data[0], 32'd3);
        end
        rsp_ready = '1;
        step("stall.pop");
        chk("stall.pop.regrant", 32'(g_last), 32'd0);
        chk("stall.pop.newdata", rsp_data[0], 32'd30);
        req_valid = '0;
        step("stall.drain");

        // reset right after an issue: the result is discarded
        set_req(1, ALU_SUB, 32'd9, 32'd4);
        req_valid = 4'b0010;
        step("rmid.iss");
        req_valid = '0;
        rst = 1'b0;
        model_reset();
        #2;
        chk("rmid.rvld", 32'(rsp_valid), 32'h0);
        chk("rmid.busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2;
        chk("rmid.rvld2", 32'(rsp_valid), 32'h0);
        chk("rmid.ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step("rmid.post");

        // fairness: all valid from pointer 0 gives 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'(i), 32'd100);
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            step($sformatf("fair%0d", c));
            chk($sformatf("fair%0d.grant", c), 32'(g_last), 32'(c % NREQ));
        end
        req_valid = 4'b0100;
        step("fair.only2");
        chk("fair.only2.grant", 32'(g_last), 32'd2);
        req_valid = '1;
        step("fair.next");
        chk("fair.next.grant", 32'(g_last), 32'd3);
        req_valid = '0;
        step("fair.drain");

        // randomized traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                set_req(i, e_aluops'(4'($urandom_range(0, 9))),
                        ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                        ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
            end
            step("rnd");
        end
        req_valid = '0;
        rsp_ready = '1;
        step("rnd.drain");
        step("rnd.idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
